// File: rtl/serial_carry_adder.sv
// Bit-serial ripple-carry adder: {carry, sum} = a + b + c_in, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-2:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_cf;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_full;

    assign w_accept   = start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_s        = r_a_sr[0] ^ r_b_sr[0] ^ r_cf;
    assign w_cout     = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_cf) | (r_b_sr[0] & r_cf);
    // The accumulator holds only the WIDTH-1 bits already produced; the current
    // bit is prepended combinationally, so the final cycle yields the full sum.
    assign w_sum_full = {w_s, r_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_cf   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_cf   <= c_in;
        end else if (r_state == S_RUN) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_acc  <= w_sum_full[WIDTH-1:1];
            r_cnt  <= r_cnt + CW'(1);
            r_cf   <= w_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (w_last) begin
            sum   <= w_sum_full;
            carry <= w_cout;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // During the last RUN cycle r_cf is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (w_last) begin
            ovf <= r_cf ^ w_cout;
        end
    end
`endif

endmodule

// File: tb/tb_serial_carry_adder.sv
// Self-checking bench for serial_carry_adder: WIDTH=4 and WIDTH=8 instances against an arithmetic model.
// Define SERIAL_ADDER_OVF_EN for both bench and RTL to check the ovf output.
module tb_serial_carry_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, cin4, busy4, done4, carry4;
    logic [3:0] a4, b4, sum4;
    logic       start8, cin8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf4, ovf8, ovf_x;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_carry_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .c_in  (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .carry (carry4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    serial_carry_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .c_in  (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .carry (carry8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    // sel picks which instance the generic tasks drive and observe (0: WIDTH=4, 1: WIDTH=8)
    logic       sel;
    logic       busy_x, done_x, carry_x;
    logic [7:0] sum_x;
    assign busy_x  = sel ? busy8  : busy4;
    assign done_x  = sel ? done8  : done4;
    assign carry_x = sel ? carry8 : carry4;
    assign sum_x   = sel ? sum8   : {4'b0000, sum4};
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_x   = sel ? ovf8   : ovf4;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint model_sum(input longint a, input longint b, input longint ci);
        return a + b + ci;
    endfunction

    function automatic bit model_ovf(input int n, input longint a, input longint b, input longint ci);
        longint half, sa, sb, s;
        half = longint'(1) << (n - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        s    = sa + sb + ci;
        return (s > half - 1) || (s < -half);
    endfunction

    task automatic drive(input bit st, input int a, input int b, input int ci);
        if (sel) begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci[0];
        end else begin
            start4 = st; a4 = a[3:0]; b4 = b[3:0]; cin4 = ci[0];
        end
    endtask

    // Called at a negedge with the selected DUT idle or in DONE; returns at the done negedge.
    task automatic go(input int a, input int b, input int ci, input bit inject, input string tag);
        int         n, e;
        longint     mask, am, bm, cm, exp;
        logic [7:0] prev_sum;
        logic       prev_c;
        n        = sel ? 8 : 4;
        mask     = (longint'(1) << n) - 1;
        am       = longint'(a) & mask;
        bm       = longint'(b) & mask;
        cm       = longint'(ci) & 1;
        exp      = model_sum(am, bm, cm);
        prev_sum = sum_x;
        prev_c   = carry_x;
        drive(1'b1, a, b, ci);
        @(negedge clk);
        e = 1;
        drive(1'b0, $urandom, $urandom, $urandom);
        check({tag, "_busy"}, 64'(busy_x), 64'd1);
        while (!done_x && e < 4 * n) begin
            drive(inject && (e == 2 || e == 3), $urandom, $urandom, $urandom);
            @(negedge clk);
            e++;
            if (!done_x) begin
                check({tag, "_hold_sum"}, 64'(sum_x), 64'(prev_sum));
                check({tag, "_hold_c"}, 64'(carry_x), 64'(prev_c));
            end
        end
        check({tag, "_latency"}, 64'(e), 64'(n + 1));
        check({tag, "_done"}, 64'(done_x), 64'd1);
        check({tag, "_busy_end"}, 64'(busy_x), 64'd0);
        check({tag, "_sum"}, 64'(sum_x), 64'(exp & mask));
        check({tag, "_carry"}, 64'(carry_x), 64'((exp >> n) & 1));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(ovf_x), 64'(model_ovf(n, am, bm, cm)));
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("excl4", 64'(busy4 & done4), 64'd0);
            check("excl8", 64'(busy8 & done8), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        sel    = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_sum4", 64'(sum4), 64'd0);
        check("rst_carry4", 64'(carry4), 64'd0);
        check("rst_sum8", 64'(sum8), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 5 + 3: 8 with signed overflow
        go(5, 3, 0, 1'b0, "t1");
        check("t1_sum_const", 64'(sum_x), 64'd8);
        check("t1_carry_const", 64'(carry_x), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("t1_ovf_const", 64'(ovf_x), 64'd1);
`endif
        @(negedge clk);

        // reset while bit 2 of 9 + 9 is in progress
        drive(1'b1, 9, 9, 0);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy4), 64'd0);
        check("rst_mid_done", 64'(done4), 64'd0);
        check("rst_mid_sum", 64'(sum4), 64'd0);
        check("rst_mid_carry", 64'(carry4), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_mid_ovf", 64'(ovf4), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_done", 64'(done4), 64'd0);
        end
        go(2, 2, 0, 1'b0, "t4");
        check("t4_sum_const", 64'(sum_x), 64'd4);

        // back-to-back: second start issued in the DONE cycle
        @(negedge clk);
        go(15, 1, 0, 1'b0, "t2a");
        check("t2a_sum_const", 64'(sum_x), 64'd0);
        check("t2a_carry_const", 64'(carry_x), 64'd1);
        go(7, 8, 1, 1'b0, "t2b");
        check("t2b_sum_const", 64'(sum_x), 64'd0);
        check("t2b_carry_const", 64'(carry_x), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check("t2b_ovf_const", 64'(ovf_x), 64'd0);
`endif

        // starts pulsed mid-run are ignored; single done pulse
        @(negedge clk);
        go(6, 4, 1, 1'b1, "t3");
        check("t3_sum_const", 64'(sum_x), 64'd11);
        @(negedge clk);
        check("t3_done_drop", 64'(done_x), 64'd0);
        check("t3_idle", 64'(busy_x), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_single_done", 64'(done_x), 64'd0);
        end

        // exhaustive WIDTH=4 sweep, back-to-back
        for (int unsigned a = 0; a < 16; a++)
            for (int unsigned b = 0; b < 16; b++)
                for (int unsigned c = 0; c < 2; c++)
                    go(int'(a), int'(b), int'(c), 1'b0, "ex4");
        @(negedge clk);

        // WIDTH=8 directed and random
        sel = 1'b1;
        @(negedge clk);
        go(200, 100, 0, 1'b0, "t5");
        check("t5_sum_const", 64'(sum_x), 64'h2C);
        check("t5_carry_const", 64'(carry_x), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check("t5_ovf_const", 64'(ovf_x), 64'd0);
`endif
        for (int i = 0; i < 3000; i++)
            go(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), 1'b0, "rnd8");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
